cosmac_bus_responder: RTL
=========================

Name: cosmac_bus_responder

Overview:
- Memory and I/O responder on the CPU side of the COSMAC-style 1802 bus driven by the as1802 core: 8-bit multiplexed address, TPA, active-low MRD/MWR, N[2:0].
- Demultiplexes the 16-bit address and serves an on-chip RAM window.
- Services INP/OUT cycles (N≠0) by steering external input data onto the bus and latching OUT bytes with a strobe.
- Sits beside the core inside the user-project wrapper, in place of off-chip memory.

Parameters:
- ADDR_BITS, 10, log2 of RAM size in bytes (RAM = 2^ADDR_BITS bytes).
- BASE, 16'h0000, RAM window base; only bits [15:ADDR_BITS] are significant.
- OPEN_BUS, 8'hFF, value driven on reads outside the window.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- address  input  8  CPU multiplexed address: high byte while tpa=1, low byte otherwise.
- tpa  input  1  high-address latch pulse, active high.
- mrd_n  input  1  memory read, active low.
- mwr_n  input  1  memory write, active low.
- n  input  3  I/O line code; nonzero only during INP/OUT.
- cpu_dout  input  8  data driven by CPU (write data).
- cpu_din  output  8  data to CPU; registered.
- inp_data  input  8  external data for the INP port selected by inp_port.
- inp_port  output  3  N code of the current INP cycle; 0 when idle.
- out_data  output  8  byte captured by the last OUT.
- out_port  output  3  N code of the last OUT.
- out_stb  output  1  one-cycle pulse when out_data/out_port update.

Behaviour:
- Reset values (cycle after rst=1): addr_hi=0, cpu_din=8'h00, inp_port=0, out_data=0, out_port=0, out_stb=0, mwr_prev=1, mrd_prev=1, n_prev=0. RAM contents are not cleared.
- Address latch: each clk with tpa=1, addr_hi <= address. Full address A = {addr_hi, address} uses the current registered addr_hi, so a cycle with tpa=1 still decodes with the old addr_hi. hit = (A[15:ADDR_BITS] == BASE[15:ADDR_BITS]).
- Read path, every clk (1-cycle latency), priority order:
  - n≠0 and mrd_n=1 (INP): cpu_din <= inp_data.
  - hit: cpu_din <= RAM[A[ADDR_BITS-1:0]].
  - otherwise: cpu_din <= OPEN_BUS.
  - The read path runs regardless of mrd_n; the CPU samples only while MRD is low.
- inp_port: registered; = n when n≠0 and mrd_n=1, else 0.
- Write path:
  - While mwr_n=0, each clk captures wa_q <= A, wd_q <= cpu_dout, whit_q <= hit.
  - On the first clk with mwr_n=1 and mwr_prev=0, if whit_q, then RAM[wa_q] <= wd_q.
  - Exactly one RAM write per MWR low pulse, using the data from the last low cycle. Misses write nothing.
  - During INP, the CPU writes inp_data to RAM through this same path (standard 1802 INP semantics).
- OUT capture: on the first clk with mrd_n=1, mrd_prev=0 and n_prev≠0:
  - out_data <= cpu_din (the memory byte presented during the OUT), out_port <= n_prev, out_stb <= 1 for exactly one cycle.
  - Otherwise out_stb <= 0.
  - n_prev and mrd_prev are registered every clk.
- Simultaneous events:
  - tpa coinciding with an MWR rising edge: the write uses wa_q, captured before the addr_hi change.
  - MRD and MWR edges in the same clk are handled independently.
  - Back-to-back MWR pulses separated by one high cycle each commit.
- Reset mid-operation:
  - mwr_prev=1 after reset, so a write pending at reset is discarded.
  - No out_stb is generated for an OUT interrupted by reset.
- Wrap-around: A=16'hFFFF is decoded like any other address. RAM index wraps modulo 2^ADDR_BITS within the window.

Test Plan:
- Write/read-back: tpa with address=8'h01, MWR low 2 cycles at low byte 8'h23 with cpu_dout=8'hA5, then read of 16'h0123 with MRD low → cpu_din=8'hA5 one cycle after address is stable.
- Out-of-window: ADDR_BITS=10, BASE=0, write 8'h5A to 16'h0400, then read 16'h0400 → 8'hFF. Read 16'h0000 → unchanged.
- OUT: RAM[16'h0010]=8'h3C, MRD low 3 cycles with n=3 at 16'h0010, then MRD high → out_data=8'h3C, out_port=3, out_stb high exactly 1 cycle.
- INP: n=5, mrd_n=1, inp_data=8'h77, MWR pulse at 16'h0020 → inp_port=5 during the cycle, cpu_din=8'h77, RAM[16'h0020]=8'h77 afterwards.
- Reset mid-write: mwr_n low with data 8'h99 at 16'h0030, assert rst for 1 cycle, release with mwr_n=1 → RAM[16'h0030] unchanged, all outputs at their reset values.
- TPA/edge coincidence: MWR rising in the same clk as tpa with a new high byte → write lands at the old address, and the new addr_hi is used from the next cycle.

Source files
------------

// File: rtl/cosmac_bus_responder.sv
// On-chip memory and I/O responder for the 1802 multiplexed bus: demuxes the
// address, serves a RAM window, and handles INP/OUT port cycles.
module cosmac_bus_responder #(
    parameter int          ADDR_BITS = 10,
    parameter logic [15:0] BASE      = 16'h0000,
    parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] address,
    input  logic       tpa,
    input  logic       mrd_n,
    input  logic       mwr_n,
    input  logic [2:0] n,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    input  logic [7:0] inp_data,
    output logic [2:0] inp_port,
    output logic [7:0] out_data,
    output logic [2:0] out_port,
    output logic       out_stb
);

    logic [7:0]           mem [0:(1 << ADDR_BITS) - 1];
    logic [7:0]           addr_hi;
    logic [15:0]          full_addr;
    logic                 hit;
    logic                 inp_cycle;
    logic                 mwr_prev;
    logic                 mrd_prev;
    logic [2:0]           n_prev;
    logic [ADDR_BITS-1:0] wa_q;
    logic [7:0]           wd_q;
    logic                 whit_q;
    logic                 commit;

    // The low byte is live on the bus; the high byte comes from the last TPA.
    assign full_addr = {addr_hi, address};
    assign hit       = (full_addr[15:ADDR_BITS] == BASE[15:ADDR_BITS]);
    assign inp_cycle = (n != 3'd0) && mrd_n;
    assign commit    = mwr_n && !mwr_prev && whit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hi  <= 8'h00;
            cpu_din  <= 8'h00;
            inp_port <= 3'd0;
            out_data <= 8'h00;
            out_port <= 3'd0;
            out_stb  <= 1'b0;
            mwr_prev <= 1'b1;
            mrd_prev <= 1'b1;
            n_prev   <= 3'd0;
            wa_q     <= '0;
            wd_q     <= 8'h00;
            whit_q   <= 1'b0;
        end else begin
            if (tpa) begin
                addr_hi <= address;
            end

            if (inp_cycle) begin
                cpu_din <= inp_data;
            end else if (hit) begin
                cpu_din <= mem[full_addr[ADDR_BITS-1:0]];
            end else begin
                cpu_din <= OPEN_BUS;
            end

            inp_port <= inp_cycle ? n : 3'd0;

            // Keep overwriting while MWR is low so the last low cycle's data wins.
            if (!mwr_n) begin
                wa_q   <= full_addr[ADDR_BITS-1:0];
                wd_q   <= cpu_dout;
                whit_q <= hit;
            end

            if (mrd_n && !mrd_prev && (n_prev != 3'd0)) begin
                out_data <= cpu_din;
                out_port <= n_prev;
                out_stb  <= 1'b1;
            end else begin
                out_stb  <= 1'b0;
            end

            mwr_prev <= mwr_n;
            mrd_prev <= mrd_n;
            n_prev   <= n;
        end
    end

    // RAM contents survive reset; only the commit qualification is reset.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            mem[wa_q] <= wd_q;
        end
    end

endmodule
